// File: rtl/stack_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_arb_pkg
//  Description : Shared types for the operand-stack arbiter: FSM state
//                encoding, the latched stack operation and a one-hot to
//                index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_arb_pkg;

    // Word width carried by the latched operation record.
    localparam int c_STK_WIDTH = 32;
    // Widest requester vector the index helper handles.
    localparam int c_MAX_REQ   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                   push;
        logic [c_STK_WIDTH-1:0] wdata;
    } stack_op_t;

    // Index of the set bit of a one-hot vector (zero if none set).
    function automatic logic [2:0] onehot_to_idx(input logic [c_MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < c_MAX_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_arb_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector. Scans the request
//                vector starting at i_ptr and wrapping, granting the first
//                active requester.
//  Ports       : i_req  - request vector
//                i_ptr  - index with highest priority this round
//                o_gnt  - one-hot grant (all zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_gnt
);

    localparam int c_PW = $clog2(NREQ);

    logic [c_PW-1:0] w_idx;
    logic            w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = c_PW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stack_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : stack_arbiter
//  Description : Shares one operand stack among NREQ requesters. Round-robin
//                grant with optional lock for multi-op sequences, occupancy
//                tracking that rejects underflow/overflow before the stack
//                sees them, and a timeout on the stack's done handshake.
//  Ports       : clk, rst_n                     - clock / async active-low reset
//                req, req_push, req_lock,
//                req_wdata                      - requester side
//                gnt, done, err, rdata, count   - requester-side results
//                stk_push, stk_trigger,
//                stk_wdata, stk_rdata, stk_done - stack side
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int WIDTH   = c_STK_WIDTH,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_push,
    input  logic [NREQ-1:0]            req_lock,
    input  logic [NREQ*WIDTH-1:0]      req_wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic                       err,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       stk_push,
    output logic                       stk_trigger,
    output logic [WIDTH-1:0]           stk_wdata,
    input  logic [WIDTH-1:0]           stk_rdata,
    input  logic                       stk_done
);

    localparam int c_PW = $clog2(NREQ);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_TW = $clog2(TIMEOUT);

    state_t            r_state;
    state_t            w_next;
    logic [NREQ-1:0]   r_gnt;
    stack_op_t         r_op;
    logic              r_err;
    logic [WIDTH-1:0]  r_rdata;
    logic [c_CW-1:0]   r_count;
    logic [c_TW-1:0]   r_timer;
    logic [c_PW-1:0]   r_ptr;

    logic [NREQ-1:0]   w_pick;
    logic [NREQ-1:0]   w_src;
    logic              w_sel_push;
    logic [WIDTH-1:0]  w_sel_wdata;
    logic              w_reject;
    logic              w_relock;
    logic              w_timeout;
    logic [c_PW-1:0]   w_owner;
    logic [c_PW-1:0]   w_ptr_next;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick)
    );

    // Operand source: the fresh winner when arbitrating, the current owner
    // when a locked owner chains another operation.
    always_comb begin
        w_src       = (r_state == IDLE) ? w_pick : r_gnt;
        w_sel_push  = |(req_push & w_src);
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_src[i]) w_sel_wdata = req_wdata[i*WIDTH +: WIDTH];
        end
    end

    // Underflow/overflow are decided from the tracked occupancy so the stack
    // never receives an illegal operation.
    assign w_reject   = r_op.push ? (r_count == c_CW'(DEPTH)) : (r_count == '0);
    assign w_relock   = |(r_gnt & req & req_lock);
    assign w_timeout  = (r_timer == c_TW'(TIMEOUT - 1));
    assign w_owner    = c_PW'(onehot_to_idx(c_MAX_REQ'(r_gnt)));
    assign w_ptr_next = (w_owner == c_PW'(NREQ - 1)) ? '0 : w_owner + c_PW'(1);

    always_comb begin
        w_next      = r_state;
        stk_trigger = 1'b0;
        done        = '0;
        err         = 1'b0;
        case (r_state)
            IDLE:    if (|req) w_next = ISSUE;
            ISSUE: begin
                stk_trigger = !w_reject;
                w_next      = w_reject ? RESP : WAIT;
            end
            WAIT:    if (stk_done || w_timeout) w_next = RESP;
            RESP: begin
                done   = r_gnt;
                err    = r_err;
                w_next = w_relock ? ISSUE : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_op    <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_count <= '0;
            r_timer <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt      <= w_pick;
                        r_op.push  <= w_sel_push;
                        r_op.wdata <= w_sel_wdata;
                        r_err      <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_timer <= '0;
                    if (w_reject) r_err <= 1'b1;
                end
                WAIT: begin
                    if (stk_done) begin
                        if (r_op.push) begin
                            r_count <= r_count + c_CW'(1);
                        end else begin
                            r_count <= r_count - c_CW'(1);
                            r_rdata <= stk_rdata;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                RESP: begin
                    r_ptr <= w_ptr_next;
                    if (w_relock) begin
                        r_op.push  <= w_sel_push;
                        r_op.wdata <= w_sel_wdata;
                        r_err      <= 1'b0;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rdata     = r_rdata;
    assign count     = r_count;
    assign stk_push  = r_op.push;
    assign stk_wdata = r_op.wdata;

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_arbiter
//  Description : Directed self-checking bench for stack_arbiter with a small
//                behavioural stack (one-cycle response gap, optional hang).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_arbiter;

    localparam int NREQ    = 3;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        req, req_push, req_lock;
    logic [95:0]       req_wdata;
    logic [2:0]        gnt, done;
    logic              err;
    logic [31:0]       rdata;
    logic [2:0]        count;
    logic              stk_push, stk_trigger;
    logic [31:0]       stk_wdata, stk_rdata;
    logic              stk_done;

    int n_chk  = 0;
    int n_fail = 0;
    bit hang   = 1'b0;

    always #5 clk = ~clk;

    stack_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_push(req_push),
        .req_lock(req_lock), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .count(count), .stk_push(stk_push),
        .stk_trigger(stk_trigger), .stk_wdata(stk_wdata),
        .stk_rdata(stk_rdata), .stk_done(stk_done)
    );

    // Behavioural stack: sees trigger at an edge, answers with stk_done one
    // cycle later. With hang set it ignores triggers entirely.
    logic [31:0] mem [0:7];
    int          sp;
    bit          pend;
    logic        op_push;
    logic [31:0] op_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= 0; pend <= 1'b0; stk_done <= 1'b0; stk_rdata <= '0;
            op_push <= 1'b0; op_data <= '0;
        end else begin
            stk_done <= 1'b0;
            if (stk_trigger && !hang) begin
                pend <= 1'b1; op_push <= stk_push; op_data <= stk_wdata;
            end else if (pend) begin
                pend     <= 1'b0;
                stk_done <= 1'b1;
                if (op_push) begin
                    mem[sp & 7] <= op_data;
                    sp <= sp + 1;
                end else begin
                    stk_rdata <= mem[(sp - 1) & 7];
                    sp <= sp - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output logic [2:0] d, output logic e, output bit ok);
        ok = 1'b0; d = '0; e = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (|done) begin d = done; e = err; ok = 1'b1; break; end
        end
    endtask

    task automatic set_wdata(input int idx, input logic [31:0] v);
        req_wdata[idx*32 +: 32] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; req_push = '0; req_lock = '0; req_wdata = '0;
        hang = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_push = '0; req_lock = '0; req_wdata = '0;
        tick(); tick();
        n_chk++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
        n_chk++; if (done !== 3'b000 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b/%b expected 000/0", done, err); end
        n_chk++; if (count !== 3'd0 || rdata !== 32'd0) begin n_fail++; $display("FAIL reset_count_rdata: got %0d/%h expected 0/0", count, rdata); end
        n_chk++; if (stk_trigger !== 1'b0 || stk_push !== 1'b0 || stk_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_stk: got %b/%b/%h expected 0/0/0", stk_trigger, stk_push, stk_wdata); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_push();
        req = 3'b001; req_push = 3'b001; set_wdata(0, 32'hDEADBEEF);
        tick(); // edge 0 -> ISSUE
        n_chk++; if (gnt !== 3'b001 || stk_trigger !== 1'b1) begin n_fail++; $display("FAIL push_issue: got gnt=%b trig=%b expected 001/1", gnt, stk_trigger); end
        n_chk++; if (stk_push !== 1'b1 || stk_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL push_stk: got %b/%h expected 1/deadbeef", stk_push, stk_wdata); end
        tick(); // edge 1 -> WAIT
        n_chk++; if (stk_trigger !== 1'b0) begin n_fail++; $display("FAIL push_trig_pulse: got %b expected 0", stk_trigger); end
        tick(); // edge 2
        n_chk++; if (done !== 3'b000) begin n_fail++; $display("FAIL push_early_done: got %b expected 000", done); end
        tick(); // edge 3 -> RESP
        n_chk++; if (done !== 3'b001 || err !== 1'b0) begin n_fail++; $display("FAIL push_done: got %b/%b expected 001/0", done, err); end
        n_chk++; if (count !== 3'd1) begin n_fail++; $display("FAIL push_count: got %0d expected 1", count); end
        req = '0;
        tick();
        n_chk++; if (done !== 3'b000 || gnt !== 3'b000) begin n_fail++; $display("FAIL push_release: got done=%b gnt=%b expected 000/000", done, gnt); end
    endtask

    task automatic test_contention();
        logic [2:0] d; logic e; bit ok;
        logic [2:0] order [4];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        do_reset();
        req = 3'b111; req_push = 3'b111;
        set_wdata(0, 32'd10); set_wdata(1, 32'd11); set_wdata(2, 32'd12);
        for (int k = 0; k < 4; k++) begin
            wait_done(d, e, ok);
            n_chk++;
            if (!ok || d !== order[k] || e !== 1'b0) begin
                n_fail++; $display("FAIL contention_order%0d: got done=%b err=%b ok=%0d expected %b/0", k, d, e, ok, order[k]);
            end
            if (k == 0) set_wdata(0, 32'd13);
            else req = req & ~d;
        end
        n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL contention_count: got %0d expected 4", count); end
        tick();
    endtask

    task automatic test_overflow();
        req = 3'b100; req_push = 3'b100; set_wdata(2, 32'd99);
        tick();
        n_chk++; if (gnt !== 3'b100 || stk_trigger !== 1'b0) begin n_fail++; $display("FAIL overflow_issue: got gnt=%b trig=%b expected 100/0", gnt, stk_trigger); end
        tick();
        n_chk++; if (done !== 3'b100 || err !== 1'b1) begin n_fail++; $display("FAIL overflow_done: got %b/%b expected 100/1", done, err); end
        n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL overflow_count: got %0d expected 4", count); end
        req = '0;
        tick();
    endtask

    task automatic test_lock();
        logic [2:0] d; logic e; bit ok;
        do_reset();
        req_push = 3'b100;
        set_wdata(2, 32'd5); req = 3'b100; wait_done(d, e, ok); req = '0; tick();
        set_wdata(2, 32'd7); req = 3'b100; wait_done(d, e, ok); req = '0; tick();
        n_chk++; if (count !== 3'd2) begin n_fail++; $display("FAIL lock_setup_count: got %0d expected 2", count); end
        req_push = 3'b001; req_lock = 3'b010; set_wdata(0, 32'hA0);
        req = 3'b010;
        tick();
        n_chk++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL lock_gnt: got %b expected 010", gnt); end
        req = 3'b011;
        wait_done(d, e, ok);
        n_chk++; if (!ok || d !== 3'b010 || rdata !== 32'd7) begin n_fail++; $display("FAIL lock_pop1: got done=%b rdata=%0d expected 010/7", d, rdata); end
        tick();
        n_chk++; if (gnt !== 3'b010 || stk_trigger !== 1'b1) begin n_fail++; $display("FAIL lock_hold: got gnt=%b trig=%b expected 010/1", gnt, stk_trigger); end
        req_lock = '0;
        wait_done(d, e, ok);
        n_chk++; if (!ok || d !== 3'b010 || rdata !== 32'd5) begin n_fail++; $display("FAIL lock_pop2: got done=%b rdata=%0d expected 010/5", d, rdata); end
        req = 3'b001;
        tick(); tick();
        n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL lock_release: got %b expected 001", gnt); end
        wait_done(d, e, ok);
        req = '0;
        n_chk++; if (!ok || d !== 3'b001 || count !== 3'd1) begin n_fail++; $display("FAIL lock_after: got done=%b count=%0d expected 001/1", d, count); end
        tick();
    endtask

    task automatic test_underflow();
        logic [2:0] d; logic e; bit ok;
        req_push = 3'b000; req = 3'b001;
        wait_done(d, e, ok);
        req = '0;
        n_chk++; if (!ok || e !== 1'b0 || rdata !== 32'hA0 || count !== 3'd0) begin n_fail++; $display("FAIL underflow_pop: got err=%b rdata=%h count=%0d expected 0/a0/0", e, rdata, count); end
        tick();
        req = 3'b001;
        tick();
        n_chk++; if (gnt !== 3'b001 || stk_trigger !== 1'b0) begin n_fail++; $display("FAIL underflow_issue: got gnt=%b trig=%b expected 001/0", gnt, stk_trigger); end
        tick();
        n_chk++; if (done !== 3'b001 || err !== 1'b1) begin n_fail++; $display("FAIL underflow_done: got %b/%b expected 001/1", done, err); end
        n_chk++; if (count !== 3'd0 || rdata !== 32'hA0) begin n_fail++; $display("FAIL underflow_state: got count=%0d rdata=%h expected 0/a0", count, rdata); end
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        logic [2:0] d; logic e; bit ok; bit early;
        hang = 1'b1; early = 1'b0;
        req_push = 3'b110; set_wdata(1, 32'h55); req = 3'b010;
        tick(); // edge 0 -> ISSUE
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (|done) early = 1'b1;
        end
        n_chk++; if (early !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", early); end
        tick(); // TIMEOUT cycles spent in WAIT
        n_chk++; if (done !== 3'b010 || err !== 1'b1) begin n_fail++; $display("FAIL timeout_done: got %b/%b expected 010/1", done, err); end
        n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL timeout_count: got %0d expected 0", count); end
        req = '0; hang = 1'b0;
        tick();
        set_wdata(2, 32'h77); req = 3'b100;
        wait_done(d, e, ok);
        req = '0;
        n_chk++; if (!ok || d !== 3'b100 || e !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL timeout_recover: got done=%b err=%b count=%0d expected 100/0/1", d, e, count); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        hang = 1'b1; seen = 1'b0;
        req_push = 3'b001; set_wdata(0, 32'h33); req = 3'b001;
        tick(); tick(); tick();
        n_chk++; if (stk_wdata !== 32'h33 || gnt !== 3'b001) begin n_fail++; $display("FAIL midrst_pre: got wdata=%h gnt=%b expected 33/001", stk_wdata, gnt); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (gnt !== 3'b000 || done !== 3'b000 || stk_push !== 1'b0 || stk_wdata !== 32'd0) begin n_fail++; $display("FAIL midrst_async: got gnt=%b done=%b push=%b wdata=%h expected 0", gnt, done, stk_push, stk_wdata); end
        n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", count); end
        req = '0; hang = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (|done) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_contention();
        test_overflow();
        test_lock();
        test_underflow();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
